// File: rtl/t03_mem_req_arbiter.sv
// rtl/t03_mem_req_arbiter.sv - multi-channel memory request arbiter with ack/timeout completion
//
// Arbitrates NUM_CH latched requesters onto one ack-handshaked memory bus.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   req_valid/write/addr/wdata/be per-channel request fields (packed, ch i at i*W)
//   req_done, req_err            one-cycle completion / timeout pulses
//   stall                        requester freeze, req_valid & ~req_done
//   rdata                        last successfully read data
//   mem_ack, mem_rdata           bus response
//   mem_read/write/addr/wdata/be registered bus request
//   grant_id                     channel currently owning the bus
module t03_mem_req_arbiter #(
  parameter int NUM_CH      = 2,
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int RR_MODE     = 0,
  parameter int TIMEOUT_CYC = 255
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            req_valid,
  input  logic [NUM_CH-1:0]            req_write,
  input  logic [NUM_CH*ADDR_W-1:0]     req_addr,
  input  logic [NUM_CH*DATA_W-1:0]     req_wdata,
  input  logic [NUM_CH*DATA_W/8-1:0]   req_be,
  output logic [NUM_CH-1:0]            req_done,
  output logic [NUM_CH-1:0]            req_err,
  output logic [NUM_CH-1:0]            stall,
  output logic [DATA_W-1:0]            rdata,
  input  logic                         mem_ack,
  input  logic [DATA_W-1:0]            mem_rdata,
  output logic                         mem_read,
  output logic                         mem_write,
  output logic [ADDR_W-1:0]            mem_addr,
  output logic [DATA_W-1:0]            mem_wdata,
  output logic [DATA_W/8-1:0]          mem_be,
  output logic [$clog2(NUM_CH)-1:0]    grant_id
);

  localparam int ID_W  = $clog2(NUM_CH);
  localparam int BE_W  = DATA_W / 8;
  localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_t;

  state_t           state, state_nxt;
  logic [ID_W-1:0]  rr_ptr;
  logic [CNT_W-1:0] cnt;
  logic             err_flag;
  logic [ID_W-1:0]  win_id;
  logic             win_found;
  logic             timeout_hit;
  int               rr_idx;

  // Winner selection. Fixed mode scans downward so the lowest set index is
  // the last assignment; round-robin scans upward from the slot after the
  // previous winner and keeps the first hit.
  always_comb begin
    win_id    = '0;
    win_found = 1'b0;
    rr_idx    = 0;
    if (RR_MODE != 0) begin
      for (int k = 1; k <= NUM_CH; k++) begin
        rr_idx = (int'(rr_ptr) + k) % NUM_CH;
        if (!win_found && req_valid[ID_W'(rr_idx)]) begin
          win_found = 1'b1;
          win_id    = ID_W'(rr_idx);
        end
      end
    end else begin
      for (int i = NUM_CH - 1; i >= 0; i--) begin
        if (req_valid[ID_W'(i)]) begin
          win_found = 1'b1;
          win_id    = ID_W'(i);
        end
      end
    end
  end

  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (win_found) state_nxt = S_BUSY;
      S_BUSY:  if (mem_ack || timeout_hit) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Completion pulses are decoded from the DONE state so they vanish
  // immediately on reset without needing their own registers.
  always_comb begin
    req_done = '0;
    req_err  = '0;
    if (state == S_DONE) begin
      req_done[grant_id] = 1'b1;
      req_err[grant_id]  = err_flag;
    end
  end

  assign stall = req_valid & ~req_done;

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      grant_id  <= '0;
      rdata     <= '0;
      rr_ptr    <= ID_W'(NUM_CH - 1);
      cnt       <= '0;
      err_flag  <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (win_found) begin
            grant_id  <= win_id;
            mem_addr  <= req_addr[int'(win_id)*ADDR_W +: ADDR_W];
            mem_wdata <= req_wdata[int'(win_id)*DATA_W +: DATA_W];
            mem_be    <= req_be[int'(win_id)*BE_W +: BE_W];
            mem_write <= req_write[win_id];
            mem_read  <= ~req_write[win_id];
            cnt       <= '0;
            err_flag  <= 1'b0;
            if (RR_MODE != 0) rr_ptr <= win_id;
          end
        end
        S_BUSY: begin
          // Ack is checked first so an ack on the last allowed cycle wins.
          if (mem_ack) begin
            if (mem_read) rdata <= mem_rdata;
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
          end else if (timeout_hit) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            err_flag  <= 1'b1;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        S_DONE: begin
          cnt      <= '0;
          err_flag <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_t03_mem_req_arbiter.sv
// tb/tb_t03_mem_req_arbiter.sv - scoreboard bench for t03_mem_req_arbiter
module tb_t03_mem_req_arbiter;

  typedef struct {
    int          ch;
    bit          wr;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  be;
    bit          err;
    logic [31:0] rdata;
    int          len;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // dut_a: 2 channels, fixed priority, timeout 8
  logic         rst_a;
  logic [1:0]   valid_a, write_a, done_a, err_a, stall_a;
  logic [63:0]  addr_a, wdata_a;
  logic [7:0]   be_a;
  logic [31:0]  rdata_a, mrdata_a, maddr_a, mwdata_a;
  logic         ack_a, mrd_a, mwr_a;
  logic [3:0]   mbe_a;
  logic [0:0]   gid_a;

  // dut_b: 4 channels, round-robin, timeout 8
  logic         rst_b;
  logic [3:0]   valid_b, write_b, done_b, err_b, stall_b;
  logic [127:0] addr_b, wdata_b;
  logic [15:0]  be_b;
  logic [31:0]  rdata_b, mrdata_b, maddr_b, mwdata_b;
  logic         ack_b, mrd_b, mwr_b;
  logic [3:0]   mbe_b;
  logic [1:0]   gid_b;

  t03_mem_req_arbiter #(.NUM_CH(2), .ADDR_W(32), .DATA_W(32), .RR_MODE(0), .TIMEOUT_CYC(8)) dut_a (
    .clk(clk), .rst(rst_a), .req_valid(valid_a), .req_write(write_a), .req_addr(addr_a),
    .req_wdata(wdata_a), .req_be(be_a), .req_done(done_a), .req_err(err_a), .stall(stall_a),
    .rdata(rdata_a), .mem_ack(ack_a), .mem_rdata(mrdata_a), .mem_read(mrd_a), .mem_write(mwr_a),
    .mem_addr(maddr_a), .mem_wdata(mwdata_a), .mem_be(mbe_a), .grant_id(gid_a));

  t03_mem_req_arbiter #(.NUM_CH(4), .ADDR_W(32), .DATA_W(32), .RR_MODE(1), .TIMEOUT_CYC(8)) dut_b (
    .clk(clk), .rst(rst_b), .req_valid(valid_b), .req_write(write_b), .req_addr(addr_b),
    .req_wdata(wdata_b), .req_be(be_b), .req_done(done_b), .req_err(err_b), .stall(stall_b),
    .rdata(rdata_b), .mem_ack(ack_b), .mem_rdata(mrdata_b), .mem_read(mrd_b), .mem_write(mwr_b),
    .mem_addr(maddr_b), .mem_wdata(mwdata_b), .mem_be(mbe_b), .grant_id(gid_b));

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc      = 0;
  exp_t q_a[$];
  exp_t q_b[$];
  exp_t cur[2];
  bit   cur_valid[2];
  bit   prev_strobe[2];
  int   age[2];
  int   done_cnt[2];
  int   ack_after[2];
  bit   ack_force[2];
  logic [31:0] last_rd_a, last_rd_b;

  function automatic exp_t mk(int ch, bit wr, logic [31:0] addr, logic [31:0] wdata,
                              logic [3:0] be, bit err, logic [31:0] rdata, int len);
    exp_t e;
    e.ch = ch; e.wr = wr; e.addr = addr; e.wdata = wdata;
    e.be = be; e.err = err; e.rdata = rdata; e.len = len;
    return e;
  endfunction

  // Bus monitor + responder for one DUT: pops the expected transaction at the
  // strobe rising edge, checks it every strobe cycle, checks the done pulse.
  task automatic monitor(input int id, input logic rd, input logic wr,
                         input logic [31:0] addr, input logic [31:0] wdata, input logic [3:0] be,
                         input int gid, input logic [7:0] done, input logic [7:0] err,
                         input logic [31:0] rdata, output logic ack);
    logic       strobe;
    logic [7:0] exp_done;
    strobe = rd | wr;
    if (strobe && !prev_strobe[id]) begin
      age[id] = 0;
      cur_valid[id] = 1'b0;
      n_checks++;
      if (id == 0 && q_a.size() > 0) begin
        cur[id] = q_a.pop_front(); cur_valid[id] = 1'b1;
      end else if (id == 1 && q_b.size() > 0) begin
        cur[id] = q_b.pop_front(); cur_valid[id] = 1'b1;
      end else begin
        n_fail++;
        $display("FAIL grant_unexpected dut%0d: got grant %0d, required no grant", id, gid);
      end
    end
    if (strobe) begin
      age[id]++;
      if (cur_valid[id]) begin
        n_checks++;
        if (gid !== cur[id].ch || wr !== cur[id].wr || rd !== !cur[id].wr || addr !== cur[id].addr ||
            wdata !== cur[id].wdata || be !== cur[id].be) begin
          n_fail++;
          $display("FAIL bus_fields dut%0d: got gid=%0d wr=%b rd=%b addr=%h wdata=%h be=%h, required gid=%0d wr=%b addr=%h wdata=%h be=%h",
                   id, gid, wr, rd, addr, wdata, be, cur[id].ch, cur[id].wr, cur[id].addr, cur[id].wdata, cur[id].be);
        end
      end
    end
    if (done !== 8'h00) begin
      done_cnt[id]++;
      n_checks++;
      if (!cur_valid[id]) begin
        n_fail++;
        $display("FAIL done_unexpected dut%0d: got done=%b, required none", id, done);
      end else begin
        exp_done = 8'(1) << cur[id].ch;
        if (done !== exp_done || err !== (cur[id].err ? exp_done : 8'h00) || rdata !== cur[id].rdata ||
            (cur[id].len != 0 && age[id] != cur[id].len)) begin
          n_fail++;
          $display("FAIL completion dut%0d: got done=%b err=%b rdata=%h strobe_len=%0d, required done=%b err=%0d rdata=%h strobe_len=%0d",
                   id, done, err, rdata, age[id], exp_done, cur[id].err, cur[id].rdata, cur[id].len);
        end
        cur_valid[id] = 1'b0;
      end
    end else if (err !== 8'h00) begin
      n_checks++;
      n_fail++;
      $display("FAIL err_without_done dut%0d: got err=%b, required 0", id, err);
    end
    ack = ack_force[id] | (strobe && ack_after[id] != 0 && age[id] == ack_after[id]);
    prev_strobe[id] = strobe;
  endtask

  task automatic step();
    logic a0, a1;
    @(posedge clk);
    #1;
    cyc++;
    monitor(0, mrd_a, mwr_a, maddr_a, mwdata_a, mbe_a, int'(gid_a), 8'(done_a), 8'(err_a), rdata_a, a0);
    monitor(1, mrd_b, mwr_b, maddr_b, mwdata_b, mbe_b, int'(gid_b), 8'(done_b), 8'(err_b), rdata_b, a1);
    ack_a = a0;
    ack_b = a1;
  endtask

  task automatic test_reset();
    rst_a = 1'b1; rst_b = 1'b1;
    step(); step();
    n_checks++;
    if ({mrd_a, mwr_a, maddr_a, mwdata_a, mbe_a, gid_a} !== '0) begin
      n_fail++; $display("FAIL reset_bus_a: got rd=%b wr=%b addr=%h wdata=%h be=%h gid=%0d, required all 0", mrd_a, mwr_a, maddr_a, mwdata_a, mbe_a, gid_a);
    end
    n_checks++;
    if ({rdata_a, done_a, err_a, stall_a} !== '0) begin
      n_fail++; $display("FAIL reset_out_a: got rdata=%h done=%b err=%b stall=%b, required all 0", rdata_a, done_a, err_a, stall_a);
    end
    n_checks++;
    if ({mrd_b, mwr_b, maddr_b, mwdata_b, mbe_b, gid_b, rdata_b, done_b, err_b, stall_b} !== '0) begin
      n_fail++; $display("FAIL reset_b: got rd=%b wr=%b addr=%h gid=%0d rdata=%h done=%b, required all 0", mrd_b, mwr_b, maddr_b, gid_b, rdata_b, done_b);
    end
    rst_a = 1'b0; rst_b = 1'b0;
    step();
  endtask

  task automatic test_single_read();
    int t0;
    t0 = done_cnt[0];
    mrdata_a = 32'hDEADBEEF; ack_after[0] = 2;
    addr_a[31:0] = 32'h0000_0010; wdata_a[31:0] = 32'h0; be_a[3:0] = 4'hF; write_a = 2'b00;
    q_a.push_back(mk(0, 1'b0, 32'h10, 32'h0, 4'hF, 1'b0, 32'hDEADBEEF, 2));
    last_rd_a = 32'hDEADBEEF;
    valid_a = 2'b01;
    #1;
    n_checks++;
    if (stall_a[0] !== 1'b1 || mrd_a !== 1'b0) begin
      n_fail++; $display("FAIL read_start: got stall0=%b mem_read=%b, required 1 and 0", stall_a[0], mrd_a);
    end
    for (int c = 0; c < 20 && done_cnt[0] == t0; c++) begin
      step();
      n_checks++;
      if (stall_a[0] !== (done_cnt[0] == t0)) begin
        n_fail++; $display("FAIL read_stall0: got %b, required %b", stall_a[0], done_cnt[0] == t0);
      end
    end
    n_checks++;
    if (done_cnt[0] == t0) begin n_fail++; $display("FAIL read_done_timeout: got no done, required done"); end
    valid_a = 2'b00; ack_after[0] = 0;
    step(); step();
  endtask

  task automatic test_fixed_priority();
    int t0;
    t0 = done_cnt[0];
    mrdata_a = 32'h1111_2222; ack_after[0] = 1;
    addr_a = {32'h200, 32'h20}; wdata_a = {32'hAAAA_0001, 32'hAAAA_0000}; be_a = 8'hFF; write_a = 2'b00;
    for (int i = 0; i < 3; i++) q_a.push_back(mk(0, 1'b0, 32'h20, 32'hAAAA_0000, 4'hF, 1'b0, 32'h1111_2222, 1));
    q_a.push_back(mk(1, 1'b0, 32'h200, 32'hAAAA_0001, 4'hF, 1'b0, 32'h1111_2222, 1));
    last_rd_a = 32'h1111_2222;
    valid_a = 2'b11;
    for (int c = 0; c < 40 && done_cnt[0] < t0 + 4; c++) begin
      step();
      if (done_cnt[0] == t0 + 3 && valid_a == 2'b11) valid_a = 2'b10;
      if (done_cnt[0] == t0 + 4) valid_a = 2'b00;
    end
    n_checks++;
    if (done_cnt[0] != t0 + 4) begin n_fail++; $display("FAIL prio_done_count: got %0d, required 4", done_cnt[0] - t0); end
    ack_after[0] = 0;
    step(); step();
  endtask

  task automatic test_write();
    int t0;
    t0 = done_cnt[0];
    mrdata_a = 32'h5555_5555; ack_after[0] = 3;
    addr_a[63:32] = 32'h100; wdata_a[63:32] = 32'h1234_5678; be_a[7:4] = 4'b0011; write_a = 2'b10;
    q_a.push_back(mk(1, 1'b1, 32'h100, 32'h1234_5678, 4'b0011, 1'b0, last_rd_a, 3));
    valid_a = 2'b10;
    for (int c = 0; c < 20 && done_cnt[0] == t0; c++) begin
      step();
      if (mwr_a) begin
        addr_a[63:32] = 32'h0000_0BAD; wdata_a[63:32] = 32'h0; be_a[7:4] = 4'hC; write_a = 2'b00;
      end
    end
    n_checks++;
    if (done_cnt[0] == t0) begin n_fail++; $display("FAIL write_done_timeout: got no done, required done"); end
    valid_a = 2'b00; ack_after[0] = 0;
    step(); step();
  endtask

  task automatic test_timeout();
    int t0;
    t0 = done_cnt[0];
    mrdata_a = 32'h7777_7777; ack_after[0] = 0;
    addr_a[31:0] = 32'h40; wdata_a[31:0] = 32'h0; be_a[3:0] = 4'hF; write_a = 2'b00;
    q_a.push_back(mk(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b1, last_rd_a, 8));
    valid_a = 2'b01;
    for (int c = 0; c < 30 && done_cnt[0] == t0; c++) begin
      step();
      if (mrd_a) valid_a = 2'b00;
    end
    n_checks++;
    if (done_cnt[0] == t0) begin n_fail++; $display("FAIL abort_done_timeout: got no done, required done"); end
    step(); step();
    mrdata_a = 32'hCAFE_F00D; ack_after[0] = 8;
    q_a.push_back(mk(0, 1'b0, 32'h40, 32'h0, 4'hF, 1'b0, 32'hCAFE_F00D, 8));
    last_rd_a = 32'hCAFE_F00D;
    valid_a = 2'b01;
    for (int c = 0; c < 30 && done_cnt[0] == t0 + 1; c++) step();
    n_checks++;
    if (done_cnt[0] != t0 + 2) begin n_fail++; $display("FAIL late_ack_done_timeout: got no done, required done"); end
    valid_a = 2'b00; ack_after[0] = 0;
    step(); step();
  endtask

  task automatic test_ack_idle();
    ack_force[0] = 1'b1;
    step();
    for (int c = 0; c < 4; c++) begin
      step();
      n_checks++;
      if (mrd_a !== 1'b0 || mwr_a !== 1'b0 || done_a !== 2'b00) begin
        n_fail++; $display("FAIL ack_idle: got rd=%b wr=%b done=%b, required 0", mrd_a, mwr_a, done_a);
      end
    end
    ack_force[0] = 1'b0;
    step();
  endtask

  task automatic test_round_robin();
    int t0, last, seen;
    t0 = done_cnt[1]; last = 0; seen = t0;
    mrdata_b = 32'hA5A5_0001; ack_after[1] = 1;
    addr_b = {32'h3000, 32'h2000, 32'h1000, 32'h0};
    wdata_b = {32'hB3, 32'hB2, 32'hB1, 32'hB0}; be_b = 16'hFFFF; write_b = 4'h0;
    q_b.push_back(mk(0, 1'b0, 32'h0000, 32'hB0, 4'hF, 1'b0, 32'hA5A5_0001, 1));
    q_b.push_back(mk(1, 1'b0, 32'h1000, 32'hB1, 4'hF, 1'b0, 32'hA5A5_0001, 1));
    q_b.push_back(mk(2, 1'b0, 32'h2000, 32'hB2, 4'hF, 1'b0, 32'hA5A5_0001, 1));
    q_b.push_back(mk(3, 1'b0, 32'h3000, 32'hB3, 4'hF, 1'b0, 32'hA5A5_0001, 1));
    q_b.push_back(mk(0, 1'b0, 32'h0000, 32'hB0, 4'hF, 1'b0, 32'hA5A5_0001, 1));
    last_rd_b = 32'hA5A5_0001;
    valid_b = 4'hF;
    for (int c = 0; c < 40 && done_cnt[1] < t0 + 5; c++) begin
      step();
      if (done_cnt[1] != seen) begin
        if (seen != t0) begin
          n_checks++;
          if (cyc - last != 3) begin n_fail++; $display("FAIL rr_period: got %0d cycles, required 3", cyc - last); end
        end
        last = cyc; seen = done_cnt[1];
      end
      if (done_cnt[1] == t0 + 5) valid_b = 4'h0;
    end
    n_checks++;
    if (done_cnt[1] != t0 + 5) begin n_fail++; $display("FAIL rr_done_count: got %0d, required 5", done_cnt[1] - t0); end
    ack_after[1] = 0;
    step(); step();
  endtask

  task automatic test_reset_mid_busy();
    int t0;
    ack_after[1] = 0;
    mrdata_b = 32'h9999_9999;
    q_b.push_back(mk(1, 1'b0, 32'h1000, 32'hB1, 4'hF, 1'b0, 32'h0, 0));
    valid_b = 4'b0010;
    for (int c = 0; c < 10 && !mrd_b; c++) step();
    step();
    rst_b = 1'b1;
    step();
    cur_valid[1] = 1'b0;
    last_rd_b = 32'h0;
    n_checks++;
    if ({mrd_b, mwr_b, maddr_b, gid_b, rdata_b, done_b, err_b} !== '0) begin
      n_fail++; $display("FAIL mid_reset_outputs: got rd=%b wr=%b addr=%h gid=%0d rdata=%h done=%b err=%b, required all 0",
                         mrd_b, mwr_b, maddr_b, gid_b, rdata_b, done_b, err_b);
    end
    rst_b = 1'b0;
    t0 = done_cnt[1];
    mrdata_b = 32'hBEEF_0000; ack_after[1] = 1;
    q_b.push_back(mk(0, 1'b0, 32'h0, 32'hB0, 4'hF, 1'b0, 32'hBEEF_0000, 1));
    valid_b = 4'b0101;
    for (int c = 0; c < 20 && done_cnt[1] == t0; c++) step();
    n_checks++;
    if (done_cnt[1] == t0) begin n_fail++; $display("FAIL post_reset_done_timeout: got no done, required done"); end
    valid_b = 4'h0; ack_after[1] = 0;
    step(); step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_a = 1'b1; valid_a = '0; write_a = '0; addr_a = '0; wdata_a = '0; be_a = '0; ack_a = 1'b0; mrdata_a = '0;
    rst_b = 1'b1; valid_b = '0; write_b = '0; addr_b = '0; wdata_b = '0; be_b = '0; ack_b = 1'b0; mrdata_b = '0;
    for (int i = 0; i < 2; i++) begin
      cur_valid[i] = 1'b0; prev_strobe[i] = 1'b0; age[i] = 0;
      done_cnt[i] = 0; ack_after[i] = 0; ack_force[i] = 1'b0;
    end
    last_rd_a = '0; last_rd_b = '0;

    test_reset();
    test_single_read();
    test_fixed_priority();
    test_write();
    test_timeout();
    test_ack_idle();
    test_round_robin();
    test_reset_mid_busy();

    n_checks++;
    if (q_a.size() != 0 || q_b.size() != 0) begin
      n_fail++; $display("FAIL leftover_expected: got %0d/%0d queued, required 0/0", q_a.size(), q_b.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/t03_mem_req_arbiter.md
Name: t03_mem_req_arbiter

Overview:
Parametrised successor to the CPU's single-port memory request unit. Arbitrates NUM_CH requesters (ch0 = instruction fetch, ch1 = load/store, further channels for DMA or a debug port) onto one ack-handshaked memory bus. Each request is latched, held until ack or timeout, and completed with a per-channel done or error pulse. Per-channel stall outputs replace the fixed freezePc/freezeInstr pair.

Parameters:
NUM_CH, 2, number of requesters (2..8)
ADDR_W, 32, address width
DATA_W, 32, data width; byte enables are DATA_W/8 bits
RR_MODE, 0, 0 = fixed priority (lowest index wins), 1 = round-robin
TIMEOUT_CYC, 255, cycles in BUSY before abort; 0 disables the timeout

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  synchronous, active-high reset
req_valid  in  NUM_CH  request pending, one bit per channel
req_write  in  NUM_CH  1 = write, 0 = read
req_addr  in  NUM_CH*ADDR_W  packed addresses; ch i at [i*ADDR_W +: ADDR_W]
req_wdata  in  NUM_CH*DATA_W  packed write data
req_be  in  NUM_CH*DATA_W/8  packed byte enables
req_done  out  NUM_CH  one-cycle completion pulse
req_err  out  NUM_CH  one-cycle timeout pulse, coincident with req_done
stall  out  NUM_CH  requester must freeze
rdata  out  DATA_W  read data captured on ack
mem_ack  in  1  bus acknowledge
mem_rdata  in  DATA_W  bus read data, valid with mem_ack
mem_read  out  1  bus read strobe
mem_write  out  1  bus write strobe
mem_addr  out  ADDR_W  bus address
mem_wdata  out  DATA_W  bus write data
mem_be  out  DATA_W/8  bus byte enables
grant_id  out  clog2(NUM_CH)  index of the channel owning the bus

Behaviour:
- Reset: state IDLE. All outputs 0, including rdata and grant_id. RR pointer = NUM_CH-1, so ch0 is first in line. Timeout counter 0.
- FSM IDLE -> BUSY -> DONE -> IDLE. The FSM is registered, and all bus outputs are registered.
- IDLE, any req_valid set: pick a winner, latch its addr, wdata, be and write into the bus registers, set grant_id, and enter BUSY. mem_read or mem_write rises on the next edge.
  - Fixed priority: lowest set index wins.
  - Round-robin: first set index searching upward from pointer+1, wrapping modulo NUM_CH. The pointer updates to the winner on grant.
- BUSY: bus outputs hold stable. The counter increments each cycle.
  - mem_ack=1: capture mem_rdata into rdata (reads only; writes leave rdata unchanged), drop the strobes, enter DONE.
  - Counter reaches TIMEOUT_CYC-1 without ack: drop the strobes, set the error flag, enter DONE.
  - ack and timeout in the same cycle: ack wins, no error.
- DONE (exactly one cycle): req_done[grant_id]=1. req_err[grant_id]=1 if aborted. rdata holds. Next state is IDLE. The counter and error flag clear.
- Latency: request sampled in IDLE at edge N gives strobe high from N+1. Ack sampled at edge M gives the done pulse in cycle M+1. Minimum is 3 cycles per transaction. Back-to-back requests from one channel are granted every 3 cycles.
- stall[i] = req_valid[i] & ~req_done[i] (combinational). The channel is frozen from request until the cycle of its done pulse.
- The requester must drop or replace req_valid in the cycle after done. A valid still high in IDLE counts as a new request.
- req_valid dropped while BUSY: the transaction still completes and done still pulses.
- Inputs change while BUSY: ignored, because the fields are latched.
- mem_ack in IDLE or DONE: ignored.
- rst mid-transaction: strobes drop at the reset edge, no done or err pulse, arbitration restarts from ch0.
- rdata keeps the last successful read until the next read ack. It does not change on timeout or on a write.

Test Plan:
- Single read: NUM_CH=2, ch0 reads 0x0000_0010, ack 2 cycles after the strobe with rdata 0xDEADBEEF -> mem_read high 2 cycles, req_done[0] pulses 1 cycle after ack, rdata=0xDEADBEEF, stall[0] high until the done cycle.
- Fixed priority: RR_MODE=0, ch0 and ch1 held valid continuously, immediate ack -> grant_id sequence 0,0,0, ch1 never granted while ch0 stays valid.
- Round-robin: RR_MODE=1, NUM_CH=4, all four channels valid, immediate ack -> grant_id 0,1,2,3,0, with a done pulse on each matching channel every 3 cycles.
- Write: ch1 writes addr 0x100, data 0x12345678, be 4'b0011 -> mem_write=1 with those values held stable until ack, rdata unchanged, req_done[1] pulses.
- Timeout: TIMEOUT_CYC=8, no ack -> strobe high 8 cycles, then req_done and req_err pulse together, rdata unchanged. Also ack in cycle 8 -> no error.
- Reset mid-BUSY: rst asserted 1 cycle during a ch1 read -> all outputs 0 next edge, no done pulse, next grant goes to ch0.
